// File: rtl/sdp_ram_arb_pkg.sv
// Shared constants and helper functions for the SDP RAM read arbiter.
// Optional feature macro (used by the top): SDP_RAM_ARB_WR_BYPASS_EN.
package sdp_ram_arb_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  // Helpers operate on a fixed maximum requester count; callers zero-extend.
  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned IDX_W   = $clog2(MAX_REQ);

  // One-hot grant: first valid requester at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n && !found) begin
        idx = 32'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (valid[IDX_W'(idx)]) begin
          gnt[IDX_W'(idx)] = 1'b1;
          found            = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  // Binary index of a one-hot vector (0 when empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant plus priority pointer register.
// Ports: clk_i, rst_ni (async active-low), valid_i (requests), grant_o (one-hot grant).
module rr_arbiter
  import sdp_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   gnt_idx_c;

  // Grant and next pointer (one past the winner, wrapping).
  always_comb begin
    grant_c   = NUM_REQ'(rr_pick(MAX_REQ'(valid_i), IDX_W'(ptr_q), NUM_REQ));
    gnt_idx_c = onehot_to_idx(MAX_REQ'(grant_c));
    ptr_d     = ptr_q;
    if (|grant_c) begin
      if (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                  ptr_d = PTR_W'(gnt_idx_c + IDX_W'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign grant_o = grant_c;

endmodule

// File: rtl/sdp_ram_read_arbiter.sv
// Round-robin shared read port in front of a simple dual-port block RAM.
// Ports: i_clock, i_reset_n (async active-low); i_req_valid/i_req_addr/o_req_ready
// (requester side, one grant per cycle); o_rsp_valid/o_rsp_data (one-hot tagged
// response one cycle after grant); i_write_enable/i_write_address/i_write_data
// (independent write port).
// Macro SDP_RAM_ARB_WR_BYPASS_EN: forward same-cycle write data on address collision.
module sdp_ram_read_arbiter
  import sdp_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  input  logic                          i_write_enable,
  input  logic [ADDR_WIDTH-1:0]         i_write_address,
  input  logic [DATA_WIDTH-1:0]         i_write_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [NUM_REQ-1:0]    grant_c;
  logic                  accept_c;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] ram_rd_q;
  logic [DATA_WIDTH-1:0] rsp_data_c;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i   (i_clock),
    .rst_ni  (i_reset_n),
    .valid_i (i_req_valid),
    .grant_o (grant_c)
  );

  // Read address of the granted requester.
  always_comb begin
    rd_addr_c = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_c[k]) rd_addr_c = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign accept_c = |grant_c;

  // Block RAM: write port, and registered read (old data on same-address collision).
  always_ff @(posedge i_clock) begin
    if (i_write_enable) mem_q[i_write_address] <= i_write_data;
  end

  always_ff @(posedge i_clock) begin
    if (accept_c) ram_rd_q <= mem_q[rd_addr_c];
  end

  // Response tag: one-hot copy of the grant.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) rsp_valid_q <= '0;
    else            rsp_valid_q <= grant_c;
  end

`ifdef SDP_RAM_ARB_WR_BYPASS_EN
  logic                  byp_hit_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  // Capture write data when it targets the address being read this cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= accept_c && i_write_enable && (i_write_address == rd_addr_c);
      byp_data_q <= i_write_data;
    end
  end

  assign rsp_data_c = byp_hit_q ? byp_data_q : ram_rd_q;
`else
  assign rsp_data_c = ram_rd_q;
`endif

  assign o_req_ready = grant_c;
  assign o_rsp_valid = rsp_valid_q;
  // Data is held at zero whenever no response is strobed (also masks the unreset RAM register).
  assign o_rsp_data  = (|rsp_valid_q) ? rsp_data_c : '0;

endmodule

// File: tb/tb_sdp_ram_read_arbiter.sv
// Self-checking bench for sdp_ram_read_arbiter: directed scenarios then random traffic
// against a behavioural model (modulo round-robin pointer, array-backed memory).
module tb_sdp_ram_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            we;
  logic [AW-1:0]   wa;
  logic [DW-1:0]   wd;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DW-1:0] mem_m [2**AW];
  int            ptr_m;

  sdp_ram_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_req_valid     (req_valid),
    .i_req_addr      (req_addr),
    .o_req_ready     (req_ready),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_data      (rsp_data),
    .i_write_enable  (we),
    .i_write_address (wa),
    .i_write_data    (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Requester chosen by round-robin from pointer p, or -1 when idle.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // One cycle: drive at negedge, check grant, then check the response after the edge.
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic w_en, input logic [AW-1:0] w_a, input logic [DW-1:0] w_d);
    int            k;
    logic [N-1:0]  exp_gnt;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_data;
    @(negedge clk);
    req_valid = v; req_addr = a; we = w_en; wa = w_a; wd = w_d;
    #1;
    k = pick(v, ptr_m);
    exp_gnt = '0;
    exp_data = '0;
    if (k >= 0) begin
      exp_gnt[k] = 1'b1;
      ra = a[k*AW +: AW];
      exp_data = mem_m[ra];
`ifdef SDP_RAM_ARB_WR_BYPASS_EN
      if (w_en && w_a == ra) exp_data = w_d;
`endif
      ptr_m = (k + 1) % N;
    end
    chk("grant", DW'(req_ready), DW'(exp_gnt));
    @(posedge clk);
    #1;
    if (w_en) mem_m[w_a] = w_d;
    chk("rsp_valid", DW'(rsp_valid), DW'(exp_gnt));
    chk("rsp_data", rsp_data, exp_data);
  endtask

  initial begin
    logic [N*AW-1:0] a;
    logic [AW-1:0]   w_a;
    req_valid = '0; req_addr = '0; we = 1'b0; wa = '0; wd = '0;
    ptr_m = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_rsp_valid", DW'(rsp_valid), '0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_ready", DW'(req_ready), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill RAM so the model knows every word.
    for (int i = 0; i < 2**AW; i++) step('0, '0, 1'b1, AW'(i), $urandom);

    // Write then read back through requester 0.
    step('0, '0, 1'b1, 5'd3, 32'hA5A5_0001);
    step(4'b0001, {4{5'd3}}, 1'b0, '0, '0);
    chk("t1_data_const", rsp_data, 32'hA5A5_0001);

    // All four held: rotating grants 1,2,3,0,1 (pointer is 1 after the read above).
    a = {5'd4, 5'd5, 5'd6, 5'd7};
    repeat (5) step(4'b1111, a, 1'b0, '0, '0);

    // Pointer is now 2: grant 2 -> ptr 3, then {1,2} valid wraps to 1, then 2.
    step(4'b0100, a, 1'b0, '0, '0);
    step(4'b0110, a, 1'b0, '0, '0);
    chk("t3_wrap_const", DW'(rsp_valid), DW'(4'b0010));
    step(4'b0110, a, 1'b0, '0, '0);

    // Same-cycle read/write collision on address 7.
    step('0, '0, 1'b1, 5'd7, 32'h0000_FFFF);
    step(4'b0001, {4{5'd7}}, 1'b1, 5'd7, 32'h0000_1234);

    // Reset right after a grant drops the response immediately.
    step(4'b0100, {4{5'd9}}, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    ptr_m = 0;
    chk("midreset_rsp_valid", DW'(rsp_valid), '0);
    chk("midreset_rsp_data", rsp_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, {4{5'd2}}, 1'b0, '0, '0);
    step(4'b1111, a, 1'b0, '0, '0);
    chk("post_reset_ptr0_const", DW'(rsp_valid), DW'(4'b0001));

    // Idle cycles keep the pointer.
    repeat (10) step('0, a, 1'b0, '0, '0);
    step(4'b1111, a, 1'b0, '0, '0);

    // Random traffic with frequent write/read collisions.
    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom};
      w_a = ($urandom_range(0, 2) == 0) ? a[$urandom_range(0, N-1)*AW +: AW] : AW'($urandom);
      step(N'($urandom), a, 1'($urandom), w_a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
